instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, redirect squashing,
// and a single-entry skid toward decode with a count of accepted instructions.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   redirect_tgt;
  logic              waiting;
  logic              unused_redirect_lsbs;

  // Redirect targets are forced word-aligned.
  assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign waiting              = (state_q == FETCH) || (state_q == KILL);

  // Next-state, pc and capture logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = imem_ack ? FETCH : KILL;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = addr_q;
          pc_d    = addr_q + XLEN'(4);
          state_d = HOLD;
        end
      end
      KILL: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_ack) state_d = FETCH;
      end
      HOLD: begin
        if (if_ready) cnt_d = cnt_q + XLEN'(1);
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (if_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // The request address is frozen while a request is outstanding.
    addr_d  = (waiting && !imem_ack) ? addr_q : pc_d;
    req_d   = (state_d == FETCH) || (state_d == KILL);
    valid_d = (state_d == HOLD);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc_plus4 = ipc_q + XLEN'(4);
  assign fetch_count = cnt_q;

endmodule
